axi_rd_burst_split: RTL and testbench
=====================================

Name: axi_rd_burst_split

Overview:
- Read-path AXI stage on the OpenIP side, directly upstream of the OpenIP-to-AXI_BUS converter.
- Splits INCR read bursts longer than MAX_BEATS into back-to-back sub-bursts on the AR channel.
- Re-merges the returning R beats so the upstream master sees a single burst with exactly one r_last.
- Non-INCR bursts (FIXED, WRAP) pass through unsplit.

Parameters:
ID_WIDTH, 4, AR/R id width
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, R data width
USER_WIDTH, 1, ar/r user width (must be >0)
MAX_BEATS, 16, maximum beats per issued sub-burst (1..256)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  upstream AR payload
s_ar_valid  in  1;  s_ar_ready  out  1
s_r_id/data/resp/last/user  out  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH  upstream R payload
s_r_valid  out  1;  s_r_ready  in  1
m_ar_* (same fields as s_ar_*)  out  as above  downstream AR payload
m_ar_valid  out  1;  m_ar_ready  in  1
m_r_id/data/resp/last/user  in  as above  downstream R payload
m_r_valid  in  1;  m_r_ready  out  1

Behaviour:
- Interface: one clock, clk; reset rstn is synchronous, active-low.
- Reset values: state=IDLE, s_ar_ready=0, m_ar_valid=0, all counters 0.
- rstn low mid-burst aborts all tracking with no draining.

FSM IDLE:
- s_ar_ready=1.
- On s_ar handshake, latch the full AR payload into req regs, set rem_beats=len+1, beat_cnt=0.
- Go to ISSUE on the cycle after acceptance; s_ar_ready deasserts in that cycle.

FSM ISSUE:
- m_ar_valid=1.
- m_ar_addr=cur_addr.
- m_ar_len=min(rem_beats,MAX_BEATS)-1 for INCR; the original len for FIXED/WRAP.
- All other fields come from the req regs.
- Payload is held stable while valid && !ready.
- On handshake:
  - cur_addr += (sub_len+1)<<size, modulo 2^ADDR_WIDTH.
  - rem_beats -= sub_len+1.
- When rem_beats reaches 0, go to WAIT_R. Otherwise issue the next sub-burst on the following cycle (no bubble required beyond one cycle).

FSM WAIT_R:
- No further AR is issued. Return to IDLE on the final merged beat handshake.
- That beat may occur in ISSUE if data overtakes AR issue; the FSM goes to IDLE only when both conditions hold.

R path:
- Combinational pass-through in all states: s_r_valid=m_r_valid, m_r_ready=s_r_ready; id/data/resp/user are forwarded unmodified.
- beat_cnt increments on each s_r handshake while a burst is tracked.
- s_r_last=m_r_last && (beat_cnt==orig_len) while tracking.
- When not tracking (IDLE), s_r_last=m_r_last.

Boundaries and latency:
- Zero latency on R.
- One cycle from s_ar handshake to the first m_ar_valid.
- len=0, or len+1<=MAX_BEATS: exactly one sub-burst, identical to the input AR.
- MAX_BEATS=256: the block degenerates to a registered AR slice.
- 4 KB compliance is inherited from the original burst; sub-bursts never extend past it.

Optional Feature:
- Macro: AXI_RD_BURST_SPLIT_STATS_EN.
- Defined:
  - Adds output split_cnt (32 bits), reset 0.
  - Increments by 1 on every m_ar handshake that is not the first sub-burst of its request.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package axi_split_pkg:
  - burst encodings BURST_FIXED/INCR/WRAP.
  - state enum split_state_e {IDLE, ISSUE, WAIT_R}.
  - AXI_LEN_W=8, AXI_SIZE_W=3.
- No sub-module; the address/length generator stays inline.

Test Plan:
- INCR len=39, size=3, addr=0x1000, MAX_BEATS=16 -> three m_ar: (0x1000, len 15), (0x1080, len 15), (0x1100, len 7); 40 R beats upstream; s_r_last only on beat 40.
- INCR len=7, MAX_BEATS=16 -> single m_ar identical to the input; s_r_last follows m_r_last on beat 8.
- WRAP len=7, addr=0x1038 -> single m_ar, len 7, addr 0x1038 unchanged, no split.
- m_ar_ready held low 5 cycles during the second sub-burst -> payload stable; s_ar_ready stays 0 until the final r_last handshake.
- rstn asserted after 10 of 40 beats -> next cycle: s_ar_ready=0, m_ar_valid=0, state IDLE; new AR accepted cleanly afterwards.
- With AXI_RD_BURST_SPLIT_STATS_EN defined: len=39, MAX_BEATS=16 -> split_cnt=2 after completion.

Source files
------------

// File: rtl/axi_split_pkg.sv
// Shared types for the AXI read burst splitter: burst encodings, FSM states and
// the sub-burst length helper used by the AR generator.
package axi_split_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } split_state_e;

  // AXI len of the next sub-burst: INCR is capped at max_beats, FIXED/WRAP keep the original len.
  function automatic logic [AXI_LEN_W-1:0] sub_len(
    input logic [AXI_LEN_W:0]   rem,
    input logic [1:0]           burst,
    input logic [AXI_LEN_W-1:0] orig_len,
    input logic [AXI_LEN_W:0]   max_beats
  );
    logic [AXI_LEN_W:0] beats;
    logic [AXI_LEN_W:0] len_w;
    if (burst != BURST_INCR) begin
      sub_len = orig_len;
    end else begin
      beats   = (rem > max_beats) ? max_beats : rem;
      len_w   = beats - 9'd1;
      sub_len = len_w[AXI_LEN_W-1:0];
    end
  endfunction

endpackage

// File: rtl/axi_rd_burst_split.sv
// Splits long INCR read bursts into MAX_BEATS sub-bursts and re-merges the R beats
// into one upstream burst. Optional split counter: AXI_RD_BURST_SPLIT_STATS_EN.
module axi_rd_burst_split
  import axi_split_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ID_WIDTH-1:0]   s_ar_id,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [AXI_LEN_W-1:0]  s_ar_len,
  input  logic [AXI_SIZE_W-1:0] s_ar_size,
  input  logic [1:0]            s_ar_burst,
  input  logic                  s_ar_lock,
  input  logic [3:0]            s_ar_cache,
  input  logic [2:0]            s_ar_prot,
  input  logic [3:0]            s_ar_qos,
  input  logic [3:0]            s_ar_region,
  input  logic [USER_WIDTH-1:0] s_ar_user,
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  output logic [ID_WIDTH-1:0]   s_r_id,
  output logic [DATA_WIDTH-1:0] s_r_data,
  output logic [1:0]            s_r_resp,
  output logic                  s_r_last,
  output logic [USER_WIDTH-1:0] s_r_user,
  output logic                  s_r_valid,
  input  logic                  s_r_ready,
  output logic [ID_WIDTH-1:0]   m_ar_id,
  output logic [ADDR_WIDTH-1:0] m_ar_addr,
  output logic [AXI_LEN_W-1:0]  m_ar_len,
  output logic [AXI_SIZE_W-1:0] m_ar_size,
  output logic [1:0]            m_ar_burst,
  output logic                  m_ar_lock,
  output logic [3:0]            m_ar_cache,
  output logic [2:0]            m_ar_prot,
  output logic [3:0]            m_ar_qos,
  output logic [3:0]            m_ar_region,
  output logic [USER_WIDTH-1:0] m_ar_user,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  input  logic [ID_WIDTH-1:0]   m_r_id,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  input  logic [1:0]            m_r_resp,
  input  logic                  m_r_last,
  input  logic [USER_WIDTH-1:0] m_r_user,
  input  logic                  m_r_valid,
  output logic                  m_r_ready
`ifdef AXI_RD_BURST_SPLIT_STATS_EN
  ,
  output logic [31:0]           split_cnt
`endif
);

  localparam logic [AXI_LEN_W:0] MAX_BEATS_C = (AXI_LEN_W+1)'(MAX_BEATS);

  split_state_e          state_r;
  split_state_e          state_s;
  logic [ID_WIDTH-1:0]   req_id_r;
  logic [AXI_LEN_W-1:0]  req_len_r;
  logic [AXI_SIZE_W-1:0] req_size_r;
  logic [1:0]            req_burst_r;
  logic                  req_lock_r;
  logic [3:0]            req_cache_r;
  logic [2:0]            req_prot_r;
  logic [3:0]            req_qos_r;
  logic [3:0]            req_region_r;
  logic [USER_WIDTH-1:0] req_user_r;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [AXI_LEN_W:0]    rem_beats_r;
  logic [AXI_LEN_W-1:0]  beat_cnt_r;
  logic [AXI_LEN_W-1:0]  sub_len_r;
  logic                  s_ar_ready_r;
  logic                  m_ar_valid_r;
  logic                  r_done_r;

  logic                  ar_hs_s;
  logic                  m_ar_hs_s;
  logic                  tracking_s;
  logic                  r_hs_s;
  logic                  beat_last_s;
  logic                  final_beat_s;
  logic [AXI_LEN_W:0]    sub_beats_s;
  logic [AXI_LEN_W:0]    rem_next_s;
  logic                  issue_done_s;
  logic [ADDR_WIDTH-1:0] addr_step_s;

  assign ar_hs_s      = s_ar_valid && s_ar_ready_r;
  assign m_ar_hs_s    = m_ar_valid_r && m_ar_ready;
  assign tracking_s   = (state_r != IDLE);
  assign r_hs_s       = m_r_valid && s_r_ready;
  assign beat_last_s  = (beat_cnt_r == req_len_r);
  assign final_beat_s = tracking_s && r_hs_s && beat_last_s && !r_done_r;
  assign sub_beats_s  = {1'b0, sub_len_r} + 9'd1;
  assign rem_next_s   = rem_beats_r - sub_beats_s;
  assign issue_done_s = m_ar_hs_s && (rem_next_s == 9'd0);
  assign addr_step_s  = ADDR_WIDTH'(sub_beats_s) << req_size_r;

  // Next state: the request retires only once every sub-burst is issued and the merged last beat is taken
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: begin
        if (issue_done_s) begin
          if (final_beat_s || r_done_r) state_s = IDLE;
          else                          state_s = WAIT_R;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_R: begin
        if (final_beat_s || r_done_r) state_s = IDLE;
        else                          state_s = WAIT_R;
      end
      default: state_s = IDLE;
    endcase
  end

  // Request payload captured on upstream acceptance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_id_r     <= '0;
      req_len_r    <= 8'd0;
      req_size_r   <= 3'd0;
      req_burst_r  <= 2'd0;
      req_lock_r   <= 1'b0;
      req_cache_r  <= 4'd0;
      req_prot_r   <= 3'd0;
      req_qos_r    <= 4'd0;
      req_region_r <= 4'd0;
      req_user_r   <= '0;
    end else if (ar_hs_s) begin
      req_id_r     <= s_ar_id;
      req_len_r    <= s_ar_len;
      req_size_r   <= s_ar_size;
      req_burst_r  <= s_ar_burst;
      req_lock_r   <= s_ar_lock;
      req_cache_r  <= s_ar_cache;
      req_prot_r   <= s_ar_prot;
      req_qos_r    <= s_ar_qos;
      req_region_r <= s_ar_region;
      req_user_r   <= s_ar_user;
    end
  end

  // FSM state, sub-burst address/length generator and merged-beat tracking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= IDLE;
      s_ar_ready_r <= 1'b0;
      m_ar_valid_r <= 1'b0;
      cur_addr_r   <= '0;
      rem_beats_r  <= 9'd0;
      beat_cnt_r   <= 8'd0;
      sub_len_r    <= 8'd0;
      r_done_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      s_ar_ready_r <= (state_s == IDLE);
      if (ar_hs_s) begin
        cur_addr_r   <= s_ar_addr;
        rem_beats_r  <= {1'b0, s_ar_len} + 9'd1;
        sub_len_r    <= sub_len({1'b0, s_ar_len} + 9'd1, s_ar_burst, s_ar_len, MAX_BEATS_C);
        beat_cnt_r   <= 8'd0;
        r_done_r     <= 1'b0;
        m_ar_valid_r <= 1'b1;
      end else begin
        if (m_ar_hs_s) begin
          cur_addr_r   <= cur_addr_r + addr_step_s;
          rem_beats_r  <= rem_next_s;
          sub_len_r    <= sub_len(rem_next_s, req_burst_r, req_len_r, MAX_BEATS_C);
          m_ar_valid_r <= (rem_next_s != 9'd0);
        end
        // r_done_r covers data that completes before the last sub-burst is accepted
        if (tracking_s && r_hs_s && !r_done_r) begin
          beat_cnt_r <= beat_cnt_r + 8'd1;
          if (beat_last_s) r_done_r <= 1'b1;
        end
      end
    end
  end

`ifdef AXI_RD_BURST_SPLIT_STATS_EN
  logic        first_sub_r;
  logic [31:0] split_cnt_r;

  // Saturating count of sub-bursts beyond the first of each request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      first_sub_r <= 1'b0;
      split_cnt_r <= 32'd0;
    end else begin
      if (ar_hs_s)        first_sub_r <= 1'b1;
      else if (m_ar_hs_s) first_sub_r <= 1'b0;
      if (m_ar_hs_s && !first_sub_r && (split_cnt_r != 32'hFFFF_FFFF)) begin
        split_cnt_r <= split_cnt_r + 32'd1;
      end
    end
  end

  assign split_cnt = split_cnt_r;
`endif

  assign s_ar_ready  = s_ar_ready_r;
  assign m_ar_valid  = m_ar_valid_r;
  assign m_ar_id     = req_id_r;
  assign m_ar_addr   = cur_addr_r;
  assign m_ar_len    = sub_len_r;
  assign m_ar_size   = req_size_r;
  assign m_ar_burst  = req_burst_r;
  assign m_ar_lock   = req_lock_r;
  assign m_ar_cache  = req_cache_r;
  assign m_ar_prot   = req_prot_r;
  assign m_ar_qos    = req_qos_r;
  assign m_ar_region = req_region_r;
  assign m_ar_user   = req_user_r;

  assign s_r_valid = m_r_valid;
  assign m_r_ready = s_r_ready;
  assign s_r_id    = m_r_id;
  assign s_r_data  = m_r_data;
  assign s_r_resp  = m_r_resp;
  assign s_r_user  = m_r_user;
  assign s_r_last  = tracking_s ? (m_r_last && beat_last_s) : m_r_last;

endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Scoreboard bench for axi_rd_burst_split: directed AR vectors with hand-computed
// sub-bursts, a responding downstream slave and a decoupled negedge monitor.
module tb_axi_rd_burst_split;
  import axi_split_pkg::*;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int USER_WIDTH = 1;
  localparam int MAX_BEATS  = 16;
  localparam logic [63:0] DBASE = 64'hDA7A_0000_0000_0000;

  logic clk = 1'b0;
  logic rstn;
  logic [3:0]  s_ar_id;
  logic [63:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic        s_ar_lock;
  logic [3:0]  s_ar_cache;
  logic [2:0]  s_ar_prot;
  logic [3:0]  s_ar_qos;
  logic [3:0]  s_ar_region;
  logic [0:0]  s_ar_user;
  logic        s_ar_valid, s_ar_ready;
  logic [3:0]  s_r_id;
  logic [63:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic [0:0]  s_r_user;
  logic        s_r_valid, s_r_ready;
  logic [3:0]  m_ar_id;
  logic [63:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [2:0]  m_ar_size;
  logic [1:0]  m_ar_burst;
  logic        m_ar_lock;
  logic [3:0]  m_ar_cache;
  logic [2:0]  m_ar_prot;
  logic [3:0]  m_ar_qos;
  logic [3:0]  m_ar_region;
  logic [0:0]  m_ar_user;
  logic        m_ar_valid, m_ar_ready;
  logic [3:0]  m_r_id;
  logic [63:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic [0:0]  m_r_user;
  logic        m_r_valid, m_r_ready;
`ifdef AXI_RD_BURST_SPLIT_STATS_EN
  logic [31:0] split_cnt;
`endif

  always #5 clk = ~clk;

  axi_rd_burst_split #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .USER_WIDTH(USER_WIDTH), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock), .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
    .s_ar_qos(s_ar_qos), .s_ar_region(s_ar_region), .s_ar_user(s_ar_user),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_user(s_r_user), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot),
    .m_ar_qos(m_ar_qos), .m_ar_region(m_ar_region), .m_ar_user(m_ar_user),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_user(m_r_user), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
`ifdef AXI_RD_BURST_SPLIT_STATS_EN
    , .split_cnt(split_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [16:0] misc;
  } ar_t;
  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic        last;
  } r_t;
  typedef struct {
    logic [3:0] id;
    logic [7:0] len;
  } sub_t;

  ar_t  exp_ar[$];
  r_t   exp_r[$];
  sub_t slave_q[$];

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   ar_hs_cnt = 0;
  int   r_hs_cnt = 0;
  int   exp_seq = 0;
  logic r_taken = 1'b0;
  logic slave_en = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: samples at negedge, pops the scoreboard on each handshake
  initial begin
    ar_t e;
    r_t  er;
    forever begin
      @(negedge clk);
      r_taken = 1'b0;
      if (rstn) begin
        if (m_ar_valid && m_ar_ready) begin
          ar_hs_cnt++;
          if (exp_ar.size() == 0) begin
            fail_now("m_ar_unexpected");
          end else begin
            e = exp_ar.pop_front();
            check("m_ar_addr", 128'(m_ar_addr), 128'(e.addr));
            check("m_ar_len", 128'(m_ar_len), 128'(e.len));
            check("m_ar_id_size_burst", 128'({m_ar_id, m_ar_size, m_ar_burst}), 128'({e.id, e.size, e.burst}));
            check("m_ar_misc", 128'({m_ar_lock, m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user}), 128'(e.misc));
          end
          slave_q.push_back('{id: m_ar_id, len: m_ar_len});
        end else if (m_ar_valid && exp_ar.size() > 0) begin
          check("m_ar_stall_addr", 128'(m_ar_addr), 128'(exp_ar[0].addr));
          check("m_ar_stall_len", 128'(m_ar_len), 128'(exp_ar[0].len));
        end
        if (s_r_valid && s_r_ready) begin
          r_hs_cnt++;
          r_taken = 1'b1;
          if (exp_r.size() == 0) begin
            fail_now("s_r_unexpected");
          end else begin
            er = exp_r.pop_front();
            check("s_r_beat", 128'({s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user}),
                  128'({er.id, er.data, 2'b00, er.last, er.id[0]}));
          end
        end
      end
    end
  end

  // Downstream slave: answers each accepted sub-burst in order, one beat per cycle
  initial begin
    sub_t       sub;
    logic       drv_active;
    logic [3:0] drv_id;
    logic [7:0] drv_len;
    logic [7:0] drv_beat;
    int         drv_seq;
    drv_active = 1'b0; drv_id = 4'd0; drv_len = 8'd0; drv_beat = 8'd0; drv_seq = 0;
    m_r_valid = 1'b0; m_r_id = 4'd0; m_r_data = 64'd0; m_r_resp = 2'b00; m_r_last = 1'b0; m_r_user = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!slave_en) begin
        drv_active = 1'b0;
        drv_seq = 0;
        slave_q.delete();
      end else begin
        if (drv_active && r_taken) begin
          drv_seq++;
          if (drv_beat == drv_len) drv_active = 1'b0;
          else drv_beat = drv_beat + 8'd1;
        end
        if (!drv_active && slave_q.size() > 0) begin
          sub = slave_q.pop_front();
          drv_active = 1'b1;
          drv_id = sub.id;
          drv_len = sub.len;
          drv_beat = 8'd0;
        end
      end
      m_r_valid = drv_active;
      m_r_id    = drv_id;
      m_r_data  = DBASE + 64'(drv_seq);
      m_r_resp  = 2'b00;
      m_r_last  = drv_active && (drv_beat == drv_len);
      m_r_user  = drv_id[0];
    end
  end

  task automatic exp_ar_push(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [16:0] misc);
    exp_ar.push_back('{id: id, addr: addr, len: len, size: size, burst: burst, misc: misc});
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [16:0] misc);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{id: id, data: DBASE + 64'(exp_seq), last: (i == int'(len))});
      exp_seq++;
    end
    @(posedge clk);
    #1;
    s_ar_id = id; s_ar_addr = addr; s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
    {s_ar_lock, s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user} = misc;
    s_ar_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ar_ready && n < 100);
    if (!s_ar_ready) begin
      fail_now("s_ar_accept_timeout");
      s_ar_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      s_ar_valid = 1'b0;
      @(negedge clk);
      check("ar_to_m_ar_one_cycle", 128'({s_ar_ready, m_ar_valid}), 128'(2'b01));
    end
  endtask

  task automatic wait_done(input bit toggle, input bit chk_busy);
    int n;
    n = 0;
    while ((exp_r.size() > 0 || exp_ar.size() > 0) && n < 1000) begin
      @(posedge clk);
      #1;
      if (toggle) s_r_ready = ~s_r_ready;
      @(negedge clk);
      if (chk_busy && exp_r.size() > 0) check("s_ar_ready_busy", 128'(s_ar_ready), 128'(1'b0));
      n++;
    end
    if (n >= 1000) fail_now("burst_completion_timeout");
    @(posedge clk);
    #1;
    s_r_ready = 1'b1;
    @(negedge clk);
    check("s_ar_ready_idle", 128'(s_ar_ready), 128'(1'b1));
  endtask

  // Directed stimulus
  initial begin
    int base;
    int n;
    rstn = 1'b0; s_ar_valid = 1'b0; s_ar_id = 4'd0; s_ar_addr = 64'd0; s_ar_len = 8'd0;
    s_ar_size = 3'd0; s_ar_burst = 2'd0; s_ar_lock = 1'b0; s_ar_cache = 4'd0; s_ar_prot = 3'd0;
    s_ar_qos = 4'd0; s_ar_region = 4'd0; s_ar_user = 1'b0; s_r_ready = 1'b1; m_ar_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s_ar_ready", 128'(s_ar_ready), 128'(1'b0));
    check("reset_m_ar_valid", 128'(m_ar_valid), 128'(1'b0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_s_ar_ready", 128'(s_ar_ready), 128'(1'b1));

    // INCR len 39 split into 16+16+8
    exp_ar_push(4'd3, 64'h1000, 8'd15, 3'd3, BURST_INCR, 17'h1_2345);
    exp_ar_push(4'd3, 64'h1080, 8'd15, 3'd3, BURST_INCR, 17'h1_2345);
    exp_ar_push(4'd3, 64'h1100, 8'd7,  3'd3, BURST_INCR, 17'h1_2345);
    send_ar(4'd3, 64'h1000, 8'd39, 3'd3, BURST_INCR, 17'h1_2345);
    wait_done(1'b0, 1'b1);
`ifdef AXI_RD_BURST_SPLIT_STATS_EN
    check("split_cnt_after_len39", 128'(split_cnt), 128'(32'd2));
`endif

    // INCR len 7 fits: passes unchanged, with R backpressure
    exp_ar_push(4'd5, 64'h1200, 8'd7, 3'd3, BURST_INCR, 17'h0_0F0F);
    send_ar(4'd5, 64'h1200, 8'd7, 3'd3, BURST_INCR, 17'h0_0F0F);
    wait_done(1'b1, 1'b1);

    // WRAP is never split
    exp_ar_push(4'd6, 64'h1038, 8'd7, 3'd3, BURST_WRAP, 17'h1_AAAA);
    send_ar(4'd6, 64'h1038, 8'd7, 3'd3, BURST_WRAP, 17'h1_AAAA);
    wait_done(1'b0, 1'b1);

    // m_ar_ready low for 5 cycles on the second sub-burst
    exp_ar_push(4'd7, 64'h2000, 8'd15, 3'd2, BURST_INCR, 17'h0_5555);
    exp_ar_push(4'd7, 64'h2040, 8'd15, 3'd2, BURST_INCR, 17'h0_5555);
    exp_ar_push(4'd7, 64'h2080, 8'd7,  3'd2, BURST_INCR, 17'h0_5555);
    base = ar_hs_cnt;
    send_ar(4'd7, 64'h2000, 8'd39, 3'd2, BURST_INCR, 17'h0_5555);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ar_hs_cnt < base + 1 && n < 50);
    m_ar_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ar_ready", 128'(s_ar_ready), 128'(1'b0));
      @(posedge clk);
    end
    #1;
    m_ar_ready = 1'b1;
    wait_done(1'b0, 1'b1);

    // len+1 = MAX_BEATS+1: one full sub-burst plus a single beat
    exp_ar_push(4'd1, 64'h4000, 8'd15, 3'd3, BURST_INCR, 17'h0_0001);
    exp_ar_push(4'd1, 64'h4080, 8'd0,  3'd3, BURST_INCR, 17'h0_0001);
    send_ar(4'd1, 64'h4000, 8'd16, 3'd3, BURST_INCR, 17'h0_0001);
    wait_done(1'b0, 1'b1);

    // single-beat burst
    exp_ar_push(4'd2, 64'h5008, 8'd0, 3'd3, BURST_INCR, 17'h1_0000);
    send_ar(4'd2, 64'h5008, 8'd0, 3'd3, BURST_INCR, 17'h1_0000);
    wait_done(1'b0, 1'b1);

    // FIXED longer than MAX_BEATS stays whole
    exp_ar_push(4'd4, 64'h6000, 8'd20, 3'd2, BURST_FIXED, 17'h0_1234);
    send_ar(4'd4, 64'h6000, 8'd20, 3'd2, BURST_FIXED, 17'h0_1234);
    wait_done(1'b0, 1'b1);

    // reset after 10 of 40 beats
    exp_ar_push(4'd9, 64'h3000, 8'd15, 3'd3, BURST_INCR, 17'h0_0000);
    exp_ar_push(4'd9, 64'h3080, 8'd15, 3'd3, BURST_INCR, 17'h0_0000);
    exp_ar_push(4'd9, 64'h3100, 8'd7,  3'd3, BURST_INCR, 17'h0_0000);
    base = r_hs_cnt;
    send_ar(4'd9, 64'h3000, 8'd39, 3'd3, BURST_INCR, 17'h0_0000);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (r_hs_cnt < base + 10 && n < 200);
    if (r_hs_cnt < base + 10) fail_now("ten_beats_timeout");
    #2;
    rstn = 1'b0;
    slave_en = 1'b0;
    exp_r.delete();
    exp_ar.delete();
    exp_seq = 0;
    @(posedge clk);
    @(negedge clk);
    check("midburst_reset_s_ar_ready", 128'(s_ar_ready), 128'(1'b0));
    check("midburst_reset_m_ar_valid", 128'(m_ar_valid), 128'(1'b0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    slave_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midburst_reset_recover_ready", 128'(s_ar_ready), 128'(1'b1));

    // clean acceptance after the abort
    exp_ar_push(4'hA, 64'h7000, 8'd15, 3'd3, BURST_INCR, 17'h1_FFFF);
    exp_ar_push(4'hA, 64'h7080, 8'd1,  3'd3, BURST_INCR, 17'h1_FFFF);
    send_ar(4'hA, 64'h7000, 8'd17, 3'd3, BURST_INCR, 17'h1_FFFF);
    wait_done(1'b0, 1'b1);
`ifdef AXI_RD_BURST_SPLIT_STATS_EN
    check("split_cnt_after_reset_len17", 128'(split_cnt), 128'(32'd1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (%0d vectors, %0d miscompares)", vec_cnt, err_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
